adder_share_arbiter: RTL and testbench

- Time-multiplexes one combinational BITS-wide adder (ports A, B, carry, sum) between NREQ requesters.
- Each requester hands over operands through a valid/ready handshake. The block registers the operands into the shared adder, captures sum/carry, and returns the result tagged with the requester ID.
- Sits between client blocks and a single adder instance; round-robin arbitration gives fairness.

---
 rtl/adder_share_pkg.sv | 6 +
 rtl/adder_share_arbiter_rr_arbiter.sv | 27 ++
 rtl/adder_share_arbiter.sv | 100 ++++++++++
 tb/tb_adder_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types for the adder-sharing arbiter: FSM state encoding and
// statistics counter width (stats exist only with ADDER_SHARE_STATS_EN).
package adder_share_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int STAT_W = 32;
endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr,
// wrapping N-1 -> 0. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);
    always_comb begin
        logic found;
        int   j;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// Time-multiplexes one external combinational adder between NREQ requesters.
// Optional ADDER_SHARE_STATS_EN adds saturating op/stall counters.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int BITS = 8,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic [BITS-1:0]      add_a,
    output logic [BITS-1:0]      add_b,
    input  logic [BITS-1:0]      add_sum,
    input  logic                 add_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_sum,
    output logic                 rsp_carry
`ifdef ADDER_SHARE_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_ops,
    output logic [STAT_W-1:0]    stat_stall
`endif
);
    state_t          state, state_nx;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx, ptr, id_q;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (|req_valid) state_nx = EXEC;
            end
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (|req_valid) begin
                    add_a <= req_a[int'(gnt_idx)*BITS +: BITS];
                    add_b <= req_b[int'(gnt_idx)*BITS +: BITS];
                    id_q  <= gnt_idx;
                    // Non-power-of-two NREQ needs an explicit wrap.
                    ptr   <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
                end
                EXEC: begin
                    rsp_sum   <= add_sum;
                    rsp_carry <= add_carry;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef ADDER_SHARE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else if (state == RESP) begin
            if (rsp_ready && stat_ops != '1)    stat_ops   <= stat_ops + 1'b1;
            if (!rsp_ready && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter (BITS=4, NREQ=3): directed table, corner
// sequences, then random traffic against a transaction-level model.
module tb_adder_share_arbiter;
    localparam int BITS = 4;
    localparam int NREQ = 3;
    localparam int IDW  = $clog2(NREQ);

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*BITS-1:0] req_a, req_b;
    logic [BITS-1:0]      add_a, add_b, add_sum;
    logic                 add_carry;
    logic                 rsp_valid, rsp_ready, rsp_carry;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_sum;
`ifdef ADDER_SHARE_STATS_EN
    logic [31:0]          stat_ops, stat_stall;
`endif

    adder_share_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_carry(add_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
`ifdef ADDER_SHARE_STATS_EN
        , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
    );

    // The shared adder itself.
    assign {add_carry, add_sum} = add_a + add_b;

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int         id;
        logic [3:0] a, b, sum;
        logic       carry;
    } vec_t;

    typedef struct {
        int         id;
        logic [4:0] total;
    } txn_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
        req_a[id*BITS +: BITS] = a;
        req_b[id*BITS +: BITS] = b;
    endtask

    // One complete operation from IDLE, holding rsp_ready low for stall cycles.
    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b, input int stall);
        set_ops(id, a, b);
        req_valid = NREQ'(1 << id);
        step();
        req_valid = '0;
        step();
        rsp_ready = 1'b0;
        repeat (stall) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    initial begin
        int gids[$];
        int gcyc[$];
        req_a = '0; req_b = '0;
        do_reset();

        // Reset state
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id",    32'(rsp_id), 0);
        chk("rst_rsp_sum",   32'(rsp_sum), 0);
        chk("rst_rsp_carry", 32'(rsp_carry), 0);
        chk("rst_add_a",     32'(add_a), 0);
        chk("rst_add_b",     32'(add_b), 0);

        // Single-requester table
        tbl[0] = '{1, 4'h9, 4'h8, 4'h1, 1'b1};
        tbl[1] = '{0, 4'h3, 4'h4, 4'h7, 1'b0};
        tbl[2] = '{2, 4'hF, 4'hF, 4'hE, 1'b1};
        tbl[3] = '{1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[4] = '{0, 4'h8, 4'h8, 4'h0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            req_a = 12'($urandom); req_b = 12'($urandom);
            set_ops(tbl[i].id, tbl[i].a, tbl[i].b);
            req_valid = NREQ'(1 << tbl[i].id);
            #1 chk("tbl_grant", 32'(req_ready), 32'(1 << tbl[i].id));
            step();
            req_valid = '0;
            #1;
            chk("tbl_exec_ready", 32'(req_ready), 0);
            chk("tbl_exec_valid", 32'(rsp_valid), 0);
            chk("tbl_add_a", 32'(add_a), 32'(tbl[i].a));
            chk("tbl_add_b", 32'(add_b), 32'(tbl[i].b));
            step();
            chk("tbl_rsp_valid", 32'(rsp_valid), 1);
            chk("tbl_rsp_id",    32'(rsp_id), 32'(tbl[i].id));
            chk("tbl_rsp_sum",   32'(rsp_sum), 32'(tbl[i].sum));
            chk("tbl_rsp_carry", 32'(rsp_carry), 32'(tbl[i].carry));
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            #1 chk("tbl_rsp_done", 32'(rsp_valid), 0);
        end

        // All valid: strict rotation, 3 cycles apart
        do_reset();
        req_valid = '1; rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            for (int j = 0; j < NREQ; j++)
                if (req_ready[j]) begin gids.push_back(j); gcyc.push_back(c); end
            step();
        end
        chk("rot_count", 32'(gids.size()), 5);
        for (int k = 0; k < 5 && k < gids.size(); k++) begin
            chk("rot_id", 32'(gids[k]), 32'(k % NREQ));
            if (k > 0) chk("rot_gap", 32'(gcyc[k] - gcyc[k-1]), 3);
        end

        // Backpressure in RESP for 5 cycles
        do_reset();
        set_ops(0, 4'h5, 4'h6);
        req_valid = 3'b001;
        step();
        req_valid = 3'b111;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_id",    32'(rsp_id), 0);
            chk("stall_sum",   32'(rsp_sum), 32'hB);
            chk("stall_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        #1 chk("stall_last_valid", 32'(rsp_valid), 1);
        step();
        rsp_ready = 1'b0;
        #1;
        chk("stall_released", 32'(rsp_valid), 0);
        chk("stall_next_grant", 32'(req_ready), 32'b010);

        // Reset while in EXEC discards the operation
        do_reset();
        set_ops(1, 4'h3, 4'h4);
        req_valid = 3'b010;
        step();
        req_valid = '0; reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rexec_valid", 32'(rsp_valid), 0);
        chk("rexec_sum",   32'(rsp_sum), 0);
        chk("rexec_add_a", 32'(add_a), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rexec_no_rsp", 32'(rsp_valid), 0);
        end
        req_valid = 3'b111;
        #1 chk("rexec_ptr0", 32'(req_ready), 32'b001);

        // Pointer wrap after granting the top requester
        do_reset();
        run_op(2, 4'h1, 4'h2, 0);
        req_valid = 3'b101;
        #1 chk("wrap_grant", 32'(req_ready), 32'b001);

`ifdef ADDER_SHARE_STATS_EN
        do_reset();
        #1;
        chk("stat_ops_rst0", stat_ops, 0);
        chk("stat_stall_rst0", stat_stall, 0);
        run_op(0, 4'h1, 4'h1, 1);
        run_op(1, 4'h2, 4'h2, 0);
        run_op(2, 4'h3, 4'h3, 1);
        run_op(0, 4'h4, 4'h4, 0);
        #1;
        chk("stat_ops", stat_ops, 4);
        chk("stat_stall", stat_stall, 2);
        do_reset();
        #1;
        chk("stat_ops_rst", stat_ops, 0);
        chk("stat_stall_rst", stat_stall, 0);
`endif

        // Random traffic against a transaction-level model
        begin
            txn_t q[$];
            int   mptr = 0, gc = 0, w;
            bit   busy = 1'b0, exp_rv;
            logic [NREQ-1:0] exp_gnt;
            do_reset();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
                req_a = 12'($urandom); req_b = 12'($urandom);
                rsp_ready = ($urandom_range(0, 3) != 0);
                #1;
                exp_rv = busy && (cyc >= gc + 2);
                chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
                exp_gnt = '0;
                w = rr_pick(req_valid, mptr);
                if (!busy && w >= 0) exp_gnt[w] = 1'b1;
                chk("rnd_grant", 32'(req_ready), 32'(exp_gnt));
                if (exp_rv && rsp_ready && q.size() > 0) begin
                    chk("rnd_rsp_id",    32'(rsp_id), 32'(q[0].id));
                    chk("rnd_rsp_sum",   32'(rsp_sum), 32'(q[0].total[3:0]));
                    chk("rnd_rsp_carry", 32'(rsp_carry), 32'(q[0].total[4]));
                    void'(q.pop_front());
                    busy = 1'b0;
                end else if (!busy && w >= 0) begin
                    q.push_back('{w, 5'(req_a[w*BITS +: BITS]) + 5'(req_b[w*BITS +: BITS])});
                    busy = 1'b1;
                    gc   = cyc;
                    mptr = (w + 1) % NREQ;
                end
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
